// File: rtl/axil_pkg.sv
// Shared types, response codes and helpers for the parametrised AXI4-Lite register slave.
package axil_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   // Widest data bus the strobe-merge helper supports; callers zero-extend into it.
   localparam int unsigned AXIL_MAX_DW   = 256;
   localparam int unsigned AXIL_MAX_STRB = AXIL_MAX_DW / 8;

   typedef enum logic [1:0] {
      WR_IDLE   = 2'd0,
      WR_COMMIT = 2'd1,
      WR_RESP   = 2'd2
   } wr_state_e;

   // Replace the bytes of old_word whose strobe bit is set with the bytes of new_word.
   function automatic logic [AXIL_MAX_DW-1:0] strb_merge(
      input logic [AXIL_MAX_DW-1:0]   old_word,
      input logic [AXIL_MAX_DW-1:0]   new_word,
      input logic [AXIL_MAX_STRB-1:0] strb
   );
      logic [AXIL_MAX_DW-1:0] merged;
      merged = old_word;
      for (int b = 0; b < int'(AXIL_MAX_STRB); b++) begin
         if (strb[b]) merged[b*8 +: 8] = new_word[b*8 +: 8];
      end
      return merged;
   endfunction

endpackage

// File: rtl/axil_mmap_decode.sv
// Address decoder: maps a byte address onto a register index and a hit flag.
module axil_mmap_decode
   import axil_pkg::*;
#(
   parameter int unsigned           ADDR_WIDTH  = 32,
   parameter int unsigned           NUM_REGS    = 4,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = '0,
   parameter int unsigned           STRIDE_LOG2 = 14,
   parameter int unsigned           IDX_W       = 2
) (
   input  logic [ADDR_WIDTH-1:0] i_addr,
   output logic [IDX_W-1:0]      o_idx,
   output logic                  o_hit
);

   logic [ADDR_WIDTH-1:0] w_slot;

   // Offset bits below the stride are discarded; anything below base or past the last slot misses.
   always_comb begin
      w_slot = (i_addr - BASE_ADDR) >> STRIDE_LOG2;
      o_hit  = (i_addr >= BASE_ADDR) && (w_slot < ADDR_WIDTH'(NUM_REGS));
      o_idx  = IDX_W'(w_slot);
   end

endmodule

// File: rtl/axilite_slave_mmap_param.sv
// Parametrised AXI4-Lite memory-mapped register slave with byte strobes, SLVERR on
// unmapped/read-only writes and per-register access pulses toward fabric logic.
// Optional macro AXIL_MMAP_HW_UPDATE_EN adds a hardware-side word load per register.
module axilite_slave_mmap_param
   import axil_pkg::*;
#(
   parameter int unsigned           DATA_WIDTH  = 32,
   parameter int unsigned           ADDR_WIDTH  = 32,
   parameter int unsigned           NUM_REGS    = 4,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = ADDR_WIDTH'(32'h0001_0000),
   parameter int unsigned           STRIDE_LOG2 = 14,
   parameter logic [NUM_REGS-1:0]   RO_MASK     = '0,
   parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0
) (
   input  logic                           clock,
   input  logic                           reset,
`ifdef AXIL_MMAP_HW_UPDATE_EN
   input  logic [NUM_REGS-1:0]            hw_wr_en,
   input  logic [NUM_REGS*DATA_WIDTH-1:0] hw_wr_data,
`endif
   input  logic [ADDR_WIDTH-1:0]          S_AXI_AWADDR,
   input  logic [2:0]                     S_AXI_AWPROT,
   input  logic                           S_AXI_AWVALID,
   output logic                           S_AXI_AWREADY,
   input  logic [DATA_WIDTH-1:0]          S_AXI_WDATA,
   input  logic [DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
   input  logic                           S_AXI_WVALID,
   output logic                           S_AXI_WREADY,
   output logic [1:0]                     S_AXI_BRESP,
   output logic                           S_AXI_BVALID,
   input  logic                           S_AXI_BREADY,
   input  logic [ADDR_WIDTH-1:0]          S_AXI_ARADDR,
   input  logic [2:0]                     S_AXI_ARPROT,
   input  logic                           S_AXI_ARVALID,
   output logic                           S_AXI_ARREADY,
   output logic [DATA_WIDTH-1:0]          S_AXI_RDATA,
   output logic [1:0]                     S_AXI_RRESP,
   output logic                           S_AXI_RVALID,
   input  logic                           S_AXI_RREADY,
   output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
   output logic [NUM_REGS-1:0]            reg_wr_pulse,
   output logic [NUM_REGS-1:0]            reg_rd_pulse
);

   localparam int unsigned IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;
   localparam int unsigned STRB_W = DATA_WIDTH / 8;

   wr_state_e               r_wr_state;
   logic                    r_aw_held;
   logic [ADDR_WIDTH-1:0]   r_aw_addr;
   logic                    r_w_held;
   logic [DATA_WIDTH-1:0]   r_w_data;
   logic [STRB_W-1:0]       r_w_strb;
   logic                    r_bvalid;
   logic [1:0]              r_bresp;
   logic                    r_rvalid;
   logic [1:0]              r_rresp;
   logic [DATA_WIDTH-1:0]   r_rdata;
   logic [NUM_REGS-1:0]     r_wr_pulse;
   logic [NUM_REGS-1:0]     r_rd_pulse;
   logic [DATA_WIDTH-1:0]   r_regs [NUM_REGS];

   logic                    w_aw_hs;
   logic                    w_w_hs;
   logic                    w_ar_hs;
   logic [IDX_W-1:0]        w_aw_idx;
   logic                    w_aw_hit;
   logic [IDX_W-1:0]        w_ar_idx;
   logic                    w_ar_hit;
   logic                    w_wr_ok;
   logic                    w_commit;
   logic                    w_unused;

   assign S_AXI_AWREADY = !r_aw_held && !r_bvalid;
   assign S_AXI_WREADY  = !r_w_held && !r_bvalid;
   assign S_AXI_ARREADY = !r_rvalid;
   assign S_AXI_BVALID  = r_bvalid;
   assign S_AXI_BRESP   = r_bresp;
   assign S_AXI_RVALID  = r_rvalid;
   assign S_AXI_RRESP   = r_rresp;
   assign S_AXI_RDATA   = r_rdata;
   assign reg_wr_pulse  = r_wr_pulse;
   assign reg_rd_pulse  = r_rd_pulse;

   assign w_aw_hs  = S_AXI_AWVALID && S_AXI_AWREADY;
   assign w_w_hs   = S_AXI_WVALID && S_AXI_WREADY;
   assign w_ar_hs  = S_AXI_ARVALID && S_AXI_ARREADY;
   assign w_wr_ok  = w_aw_hit && !RO_MASK[w_aw_idx];
   assign w_commit = (r_wr_state == WR_COMMIT);
   // Protection attributes carry no meaning for this register file.
   assign w_unused = ^{S_AXI_AWPROT, S_AXI_ARPROT};

   // Held write address decode (evaluated during the commit cycle).
   axil_mmap_decode #(
      .ADDR_WIDTH  (ADDR_WIDTH),
      .NUM_REGS    (NUM_REGS),
      .BASE_ADDR   (BASE_ADDR),
      .STRIDE_LOG2 (STRIDE_LOG2),
      .IDX_W       (IDX_W)
   ) u_aw_dec (
      .i_addr (r_aw_addr),
      .o_idx  (w_aw_idx),
      .o_hit  (w_aw_hit)
   );

   // Live read address decode (evaluated on the AR handshake).
   axil_mmap_decode #(
      .ADDR_WIDTH  (ADDR_WIDTH),
      .NUM_REGS    (NUM_REGS),
      .BASE_ADDR   (BASE_ADDR),
      .STRIDE_LOG2 (STRIDE_LOG2),
      .IDX_W       (IDX_W)
   ) u_ar_dec (
      .i_addr (S_AXI_ARADDR),
      .o_idx  (w_ar_idx),
      .o_hit  (w_ar_hit)
   );

   // Write FSM: collect AW and W independently, commit for one cycle, then hold B until BREADY.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_wr_state <= WR_IDLE;
         r_aw_held  <= 1'b0;
         r_aw_addr  <= '0;
         r_w_held   <= 1'b0;
         r_w_data   <= '0;
         r_w_strb   <= '0;
         r_bvalid   <= 1'b0;
         r_bresp    <= RESP_OKAY;
         r_wr_pulse <= '0;
      end else begin
         r_wr_pulse <= '0;
         case (r_wr_state)
            WR_IDLE: begin
               if (w_aw_hs) begin
                  r_aw_held <= 1'b1;
                  r_aw_addr <= S_AXI_AWADDR;
               end
               if (w_w_hs) begin
                  r_w_held <= 1'b1;
                  r_w_data <= S_AXI_WDATA;
                  r_w_strb <= S_AXI_WSTRB;
               end
               if ((r_aw_held || w_aw_hs) && (r_w_held || w_w_hs)) r_wr_state <= WR_COMMIT;
            end
            WR_COMMIT: begin
               r_aw_held  <= 1'b0;
               r_w_held   <= 1'b0;
               r_bvalid   <= 1'b1;
               r_bresp    <= w_wr_ok ? RESP_OKAY : RESP_SLVERR;
               if (w_wr_ok) r_wr_pulse[w_aw_idx] <= 1'b1;
               r_wr_state <= WR_RESP;
            end
            WR_RESP: begin
               if (S_AXI_BREADY) begin
                  r_bvalid   <= 1'b0;
                  r_wr_state <= WR_IDLE;
               end
            end
            default: r_wr_state <= WR_IDLE;
         endcase
      end
   end

   // Register storage: hardware loads first, a same-edge bus commit to the same register overrides.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < int'(NUM_REGS); i++) r_regs[i] <= RESET_VALUE;
      end else begin
         for (int i = 0; i < int'(NUM_REGS); i++) begin
`ifdef AXIL_MMAP_HW_UPDATE_EN
            if (hw_wr_en[i]) r_regs[i] <= hw_wr_data[i*DATA_WIDTH +: DATA_WIDTH];
`endif
            if (w_commit && w_wr_ok && (w_aw_idx == IDX_W'(i))) begin
               r_regs[i] <= DATA_WIDTH'(strb_merge(AXIL_MAX_DW'(r_regs[i]),
                                                   AXIL_MAX_DW'(r_w_data),
                                                   AXIL_MAX_STRB'(r_w_strb)));
            end
         end
      end
   end

   // Read channel: one-cycle registered response, held until RREADY.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         r_rvalid   <= 1'b0;
         r_rresp    <= RESP_OKAY;
         r_rdata    <= '0;
         r_rd_pulse <= '0;
      end else begin
         r_rd_pulse <= '0;
         if (w_ar_hs) begin
            r_rvalid <= 1'b1;
            r_rresp  <= w_ar_hit ? RESP_OKAY : RESP_SLVERR;
            r_rdata  <= w_ar_hit ? r_regs[w_ar_idx] : '0;
            if (w_ar_hit) r_rd_pulse[w_ar_idx] <= 1'b1;
         end else if (r_rvalid && S_AXI_RREADY) begin
            r_rvalid <= 1'b0;
         end
      end
   end

   // Flattened register view for fabric logic.
   for (genvar g = 0; g < int'(NUM_REGS); g++) begin : g_reg_out
      assign reg_out[g*DATA_WIDTH +: DATA_WIDTH] = r_regs[g];
   end

endmodule

// File: tb/tb_axilite_slave_mmap_param.sv
// Directed bench for axilite_slave_mmap_param with a response scoreboard (RO_MASK = 4'b1000).
module tb_axilite_slave_mmap_param;

   localparam logic [1:0] OKAY   = 2'b00;
   localparam logic [1:0] SLVERR = 2'b10;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [31:0]  awaddr = '0;
   logic [2:0]   awprot = '0;
   logic         awvalid = 1'b0;
   logic         awready;
   logic [31:0]  wdata = '0;
   logic [3:0]   wstrb = '0;
   logic         wvalid = 1'b0;
   logic         wready;
   logic [1:0]   bresp;
   logic         bvalid;
   logic         bready = 1'b0;
   logic [31:0]  araddr = '0;
   logic [2:0]   arprot = '0;
   logic         arvalid = 1'b0;
   logic         arready;
   logic [31:0]  rdata;
   logic [1:0]   rresp;
   logic         rvalid;
   logic         rready = 1'b0;
   logic [127:0] reg_out;
   logic [3:0]   reg_wr_pulse;
   logic [3:0]   reg_rd_pulse;
`ifdef AXIL_MMAP_HW_UPDATE_EN
   logic [3:0]   hw_wr_en = '0;
   logic [127:0] hw_wr_data = '0;
`endif

   int checks = 0;
   int errors = 0;
   int wr_cnt [4];
   int rd_cnt [4];
   logic [1:0]  wq [$];
   logic [33:0] rq [$];

   always #5 clk = ~clk;

   axilite_slave_mmap_param #(
      .RO_MASK (4'b1000)
   ) dut (
      .clock         (clk),
      .reset         (rst_n),
`ifdef AXIL_MMAP_HW_UPDATE_EN
      .hw_wr_en      (hw_wr_en),
      .hw_wr_data    (hw_wr_data),
`endif
      .S_AXI_AWADDR  (awaddr),
      .S_AXI_AWPROT  (awprot),
      .S_AXI_AWVALID (awvalid),
      .S_AXI_AWREADY (awready),
      .S_AXI_WDATA   (wdata),
      .S_AXI_WSTRB   (wstrb),
      .S_AXI_WVALID  (wvalid),
      .S_AXI_WREADY  (wready),
      .S_AXI_BRESP   (bresp),
      .S_AXI_BVALID  (bvalid),
      .S_AXI_BREADY  (bready),
      .S_AXI_ARADDR  (araddr),
      .S_AXI_ARPROT  (arprot),
      .S_AXI_ARVALID (arvalid),
      .S_AXI_ARREADY (arready),
      .S_AXI_RDATA   (rdata),
      .S_AXI_RRESP   (rresp),
      .S_AXI_RVALID  (rvalid),
      .S_AXI_RREADY  (rready),
      .reg_out       (reg_out),
      .reg_wr_pulse  (reg_wr_pulse),
      .reg_rd_pulse  (reg_rd_pulse)
   );

   // Count access pulses; each pulse is one cycle wide so it is seen at exactly one falling edge.
   always @(negedge clk) begin
      if (rst_n) begin
         for (int i = 0; i < 4; i++) begin
            if (reg_wr_pulse[i]) wr_cnt[i]++;
            if (reg_rd_pulse[i]) rd_cnt[i]++;
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Write with AW and W presented together; BREADY held low for 'hold' cycles once BVALID is up.
   task automatic axi_write(input logic [31:0] addr, input logic [31:0] data,
                            input logic [3:0] strb, input logic [1:0] eresp, input int hold);
      int   n;
      logic a;
      logic w;
      logic stable;
      logic [1:0] r0;
      logic [1:0] e;
      wq.push_back(eresp);
      awaddr = addr; awvalid = 1'b1;
      wdata = data; wstrb = strb; wvalid = 1'b1;
      n = 0;
      while ((awvalid || wvalid) && n < 50) begin
         a = awvalid && awready;
         w = wvalid && wready;
         tick();
         if (a) awvalid = 1'b0;
         if (w) wvalid = 1'b0;
         n++;
      end
      chk("wr_addr_data_accept", {62'd0, awvalid, wvalid}, 64'd0);
      awvalid = 1'b0; wvalid = 1'b0;
      n = 0;
      while (!bvalid && n < 50) begin tick(); n++; end
      chk("bvalid_seen", bvalid, 1);
      chk("bvalid_latency", n, 1);
      if (hold > 0) begin
         stable = 1'b1; r0 = bresp;
         for (int h = 0; h < hold; h++) begin
            if (!bvalid || bresp !== r0 || awready || wready) stable = 1'b0;
            tick();
         end
         chk("b_hold_stable", stable, 1);
      end
      e = wq.pop_front();
      chk("bresp", bresp, e);
      bready = 1'b1;
      tick();
      bready = 1'b0;
      chk("b_release", bvalid, 0);
   endtask

   // Read; RREADY held low for 'hold' cycles once RVALID is up.
   task automatic axi_read(input logic [31:0] addr, input logic [31:0] edata,
                           input logic [1:0] eresp, input int hold);
      int   n;
      logic stable;
      logic [31:0] d0;
      logic [33:0] e;
      rq.push_back({eresp, edata});
      araddr = addr; arvalid = 1'b1;
      n = 0;
      while (!arready && n < 50) begin tick(); n++; end
      chk("ar_ready_seen", arready, 1);
      tick();
      arvalid = 1'b0;
      n = 0;
      while (!rvalid && n < 50) begin tick(); n++; end
      chk("rvalid_seen", rvalid, 1);
      chk("rvalid_latency", n, 0);
      if (hold > 0) begin
         stable = 1'b1; d0 = rdata;
         for (int h = 0; h < hold; h++) begin
            if (!rvalid || rdata !== d0 || arready) stable = 1'b0;
            tick();
         end
         chk("r_hold_stable", stable, 1);
      end
      e = rq.pop_front();
      chk("rdata", rdata, e[31:0]);
      chk("rresp", rresp, e[33:32]);
      rready = 1'b1;
      tick();
      rready = 1'b0;
      chk("r_release", rvalid, 0);
   endtask

   initial begin
      logic [1:0] e;
      logic quiet;

      // Reset state
      repeat (3) tick();
      chk("rst_bvalid", bvalid, 0);
      chk("rst_rvalid", rvalid, 0);
      chk("rst_rdata", rdata, 0);
      chk("rst_resp", {bresp, rresp}, 0);
      chk("rst_regs", reg_out[63:0], 0);
      chk("rst_regs_hi", reg_out[127:64], 0);
      chk("rst_pulses", {reg_wr_pulse, reg_rd_pulse}, 0);
      rst_n = 1'b1;
      tick();
      chk("post_rst_awready", awready, 1);
      chk("post_rst_wready", wready, 1);
      chk("post_rst_arready", arready, 1);

      // 1: all registers read zero
      for (int i = 0; i < 4; i++) axi_read(32'h0001_0000 + 32'(i) * 32'h4000, 32'h0, OKAY, 0);
      for (int i = 0; i < 4; i++) chk("rd_pulse_count", rd_cnt[i], 1);

      // 2: full write then partial strobe write
      axi_write(32'h0001_4000, 32'h1234_5678, 4'b1111, OKAY, 0);
      chk("reg1_full", reg_out[63:32], 32'h1234_5678);
      axi_write(32'h0001_4000, 32'hFFFF_FFFF, 4'b0011, OKAY, 0);
      axi_read(32'h0001_4000, 32'h1234_FFFF, OKAY, 0);
      chk("wr_pulse_reg1", wr_cnt[1], 2);
      axi_read(32'h0001_4004, 32'h1234_FFFF, OKAY, 0);

      // 3: W arrives three cycles before AW
      wq.push_back(OKAY);
      wdata = 32'hABCD_EF01; wstrb = 4'hF; wvalid = 1'b1;
      tick();
      wvalid = 1'b0;
      chk("w_held_wready", wready, 0);
      tick();
      tick();
      chk("w_held_no_bvalid", bvalid, 0);
      chk("w_held_awready", awready, 1);
      awaddr = 32'h0001_8000; awvalid = 1'b1;
      tick();
      awvalid = 1'b0;
      chk("commit_cycle_bvalid", bvalid, 0);
      tick();
      chk("second_cycle_bvalid", bvalid, 1);
      e = wq.pop_front();
      chk("early_w_bresp", bresp, e);
      bready = 1'b1;
      tick();
      bready = 1'b0;
      chk("reg2_value", reg_out[95:64], 32'hABCD_EF01);
      chk("wr_pulse_reg2", wr_cnt[2], 1);

      // 4: read-only write and unmapped accesses
      axi_write(32'h0001_C000, 32'h8765_4321, 4'b1111, SLVERR, 0);
      chk("ro_unchanged", reg_out[127:96], 0);
      chk("ro_no_pulse", wr_cnt[3], 0);
      axi_read(32'h0001_C000, 32'h0, OKAY, 0);
      axi_read(32'h0002_0000, 32'h0, SLVERR, 0);
      axi_read(32'h0000_FFFC, 32'h0, SLVERR, 0);
      axi_write(32'h0002_0000, 32'h5555_5555, 4'b1111, SLVERR, 0);
      chk("rd_pulse_reg3", rd_cnt[3], 2);

      // 5: back-pressure on B and R
      axi_write(32'h0001_0000, 32'h5A5A_0F0F, 4'b1111, OKAY, 5);
      axi_read(32'h0001_0000, 32'h5A5A_0F0F, OKAY, 5);

      // 6: reset with only AW held
      awaddr = 32'h0001_4000; awvalid = 1'b1;
      tick();
      awvalid = 1'b0;
      chk("aw_held_awready", awready, 0);
      rst_n = 1'b0;
      #1;
      chk("midrst_regs", reg_out, 128'd0);
      chk("midrst_bvalid", bvalid, 0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      chk("after_rst_ready", {awready, wready}, 2'b11);
      quiet = 1'b1;
      for (int h = 0; h < 5; h++) begin
         if (bvalid) quiet = 1'b0;
         tick();
      end
      chk("no_stale_bvalid", quiet, 1);
      axi_read(32'h0001_4000, 32'h0, OKAY, 0);
      axi_write(32'h0001_0000, 32'hCAFE_BABE, 4'b1111, OKAY, 0);
      axi_read(32'h0001_0000, 32'hCAFE_BABE, OKAY, 0);
      chk("scoreboard_empty", {wq.size(), rq.size()}, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/axilite_slave_mmap_param.md
Name: axilite_slave_mmap_param

Overview:
Parametrised AXI4-Lite memory-mapped register slave; successor to the fixed 4-register 32x32 mmap slave.
- Generalised in data width, register count, base address and stride, with a per-register read-only mask.
- Adds WSTRB byte enables, SLVERR on unmapped or read-only accesses, and independent AW/W acceptance.
- Exports register contents and per-register access pulses to fabric logic behind the AXI-Lite master.

Parameters:
DATA_WIDTH, 32, AXI data width (multiple of 8)
ADDR_WIDTH, 32, AXI address width
NUM_REGS, 4, number of registers (>=1)
BASE_ADDR, 32'h0001_0000, address of register 0
STRIDE_LOG2, 14, log2 byte stride between registers (default gives 0x10000/0x14000/0x18000/0x1C000)
RO_MASK, 0, bit i=1 makes register i bus-read-only
RESET_VALUE, 0, reset value of every register

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-low reset
S_AXI_AWADDR/AWPROT/AWVALID/AWREADY  in/in/in/out  ADDR_WIDTH/3/1/1  write address channel
S_AXI_WDATA/WSTRB/WVALID/WREADY  in/in/in/out  DATA_WIDTH/DATA_WIDTH/8/1/1  write data channel
S_AXI_BRESP/BVALID/BREADY  out/out/in  2/1/1  write response channel
S_AXI_ARADDR/ARPROT/ARVALID/ARREADY  in/in/in/out  ADDR_WIDTH/3/1/1  read address channel
S_AXI_RDATA/RRESP/RVALID/RREADY  out/out/out/in  DATA_WIDTH/2/1/1  read data channel
reg_out  out  NUM_REGS*DATA_WIDTH  flattened register contents; reg i at [i*DATA_WIDTH +: DATA_WIDTH]
reg_wr_pulse  out  NUM_REGS  1-cycle pulse on each successful bus write to reg i
reg_rd_pulse  out  NUM_REGS  1-cycle pulse on each successful bus read of reg i

Behaviour:
Reset (reset low, asynchronous):
- All registers = RESET_VALUE.
- All VALIDs, pulses, BRESP, RRESP and RDATA = 0.
- AWREADY and WREADY = 1 on the first cycle after reset deasserts.

Address decode:
- Access hits when addr >= BASE_ADDR and idx = (addr-BASE_ADDR)>>STRIDE_LOG2 < NUM_REGS.
- Offset bits below STRIDE_LOG2 are ignored. AxPROT is ignored.

Write path:
- AW and W are captured independently into single-entry holding registers.
- AWREADY = !aw_held && !BVALID; WREADY = !w_held && !BVALID.
- Commit happens on the edge after both are held. On that edge:
  - Register bytes with WSTRB=1 update.
  - BVALID rises.
  - reg_wr_pulse[idx] is high for the following cycle.
  - Holding registers clear.
- Miss, or RO_MASK[idx]=1: no update, no pulse, BRESP=2'b10 (SLVERR). Otherwise BRESP=2'b00 (OKAY).
- BVALID/BRESP hold until BREADY; BREADY high at the rising edge of BVALID is allowed.
- States: WR_IDLE (collecting) -> WR_COMMIT (both held, one cycle) -> WR_RESP (BVALID high) -> WR_IDLE on BREADY.
- Best-case latency from simultaneous AW+W handshake to BVALID: 2 cycles.

Read path:
- ARREADY = !RVALID.
- On the AR handshake edge, RDATA/RRESP/RVALID are registered (1-cycle latency) and reg_rd_pulse[idx] is high for the next cycle.
- Miss: RDATA=0, RRESP=SLVERR, no pulse. RO registers read normally with OKAY.
- RVALID/RDATA hold stable until RREADY.

Simultaneous events:
- A read of a register committed on the same edge returns the old value.
- Read and write channels are fully independent.
- Reset mid-transaction drops all pending state; no response is issued.

Optional Feature:
Macro AXIL_MMAP_HW_UPDATE_EN.
- Defined: adds ports hw_wr_en (NUM_REGS) and hw_wr_data (NUM_REGS*DATA_WIDTH).
  - hw_wr_en[i] loads the full word into register i, including RO registers.
  - A bus commit to the same register on the same edge wins; the hardware write is dropped.
- Undefined: no such ports; registers change only via the bus.

Decomposition:
- Package axil_pkg:
  - RESP_OKAY=2'b00, RESP_SLVERR=2'b10.
  - Write-FSM state enum (WR_IDLE, WR_COMMIT, WR_RESP).
  - Function for strobe-merging a word.
- One sub-module, axil_mmap_decode (combinational): addr -> idx, hit. Instantiated twice, once for AW and once for AR.

Test Plan:
1. Reset, then read 0x10000..0x1C000 -> all return 0x00000000, RRESP=00.
2. Write 0x14000=0x12345678 with WSTRB=4'b1111, then WSTRB=4'b0011 with data 0xFFFFFFFF -> read 0x1234FFFF; reg_wr_pulse[1] pulses twice.
3. Drive WVALID 3 cycles before AWVALID (0x18000, 0xABCDEF01) -> W held, BVALID 2 cycles after AW handshake, register = 0xABCDEF01.
4. RO_MASK=4'b1000: write 0x1C000=0x87654321 -> BRESP=10, register unchanged. Read 0x20000 -> RDATA=0, RRESP=10.
5. Hold BREADY/RREADY low 5 cycles -> BVALID/RVALID and data stable; AWREADY/ARREADY stay low until released.
6. Assert reset mid-write (AW held, W not yet) -> all registers return to RESET_VALUE, no BVALID; a fresh write afterwards completes with OKAY.
